// File: rtl/mcpu_ram_ctrl_sync.sv
// mcpu_ram_ctrl_sync: dual-port word RAM controller for the microCPU.
// Data port (read/write) and instruction-fetch port (read-only) share one array.
// Each port runs its own IDLE -> BUSY -> IDLE handshake FSM. Writes acknowledge
// one cycle after acceptance; reads acknowledge RD_LATENCY cycles after acceptance.
// Optional feature macro: MCPU_RAM_CLEAR_EN -- zero the whole array after reset.
module mcpu_ram_ctrl_sync #(
  parameter int WORD_SIZE  = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int RAM_SIZE   = 1 << ADDR_WIDTH,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [WORD_SIZE-1:0]  d_wdata,
  output logic                  d_ready,
  output logic                  d_ack,
  output logic [WORD_SIZE-1:0]  d_rdata,
  output logic                  d_err,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_ready,
  output logic                  i_ack,
  output logic [WORD_SIZE-1:0]  i_rdata
);

  localparam int CNT_W = $clog2(RD_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LATENCY - 1);
  localparam logic [ADDR_WIDTH:0] RAM_LIMIT = (ADDR_WIDTH + 1)'(RAM_SIZE);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_CLEAR} state_t;

  logic [WORD_SIZE-1:0] mem [0:RAM_SIZE-1];

  state_t d_state, d_state_next;
  state_t i_state, i_state_next;
  logic [CNT_W-1:0] d_cnt, d_cnt_next;
  logic [CNT_W-1:0] i_cnt, i_cnt_next;
  logic d_we_pend, d_err_pend;
  logic [WORD_SIZE-1:0] d_buf, i_buf;
  logic d_ack_next, d_err_next, i_ack_next;
  logic [WORD_SIZE-1:0] d_rdata_next, i_rdata_next;
  logic d_accept, i_accept;
  logic d_in_range, i_in_range;
  logic d_wr_en;
  logic wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [WORD_SIZE-1:0] wr_data;
  logic clr_last;

  assign d_accept   = d_req & d_ready;
  assign i_accept   = i_req & i_ready;
  assign d_in_range = ({1'b0, d_addr} < RAM_LIMIT);
  assign i_in_range = ({1'b0, i_addr} < RAM_LIMIT);
  // Out-of-range writes are dropped here so they never touch the array.
  assign d_wr_en    = d_accept & d_we & d_in_range;

`ifdef MCPU_RAM_CLEAR_EN
  localparam state_t RESET_STATE = ST_CLEAR;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic clr_active;

  assign clr_active = (d_state == ST_CLEAR);
  assign clr_last   = clr_active && (clr_addr == ADDR_WIDTH'(RAM_SIZE - 1));
  assign wr_en      = clr_active | d_wr_en;
  assign wr_addr    = clr_active ? clr_addr : d_addr;
  assign wr_data    = clr_active ? '0 : d_wdata;

  // Clear pointer walks the array once; reset always restarts it at address 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      clr_addr <= '0;
    else if (clr_active && !clr_last)
      clr_addr <= clr_addr + 1'b1;
  end
`else
  localparam state_t RESET_STATE = ST_IDLE;
  assign clr_last = 1'b0;
  assign wr_en    = d_wr_en;
  assign wr_addr  = d_addr;
  assign wr_data  = d_wdata;
`endif

  // Array write port plus both read ports, all sampled on the acceptance edge.
  // The fetch port bypasses a same-edge data write to the same word (write-first).
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_addr] <= wr_data;
    if (d_accept)
      d_buf <= d_in_range ? mem[d_addr] : '0;
    if (i_accept) begin
      if (!i_in_range)
        i_buf <= '0;
      else if (d_wr_en && (d_addr == i_addr))
        i_buf <= d_wdata;
      else
        i_buf <= mem[i_addr];
    end
  end

  // Data port state, latency counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_state    <= RESET_STATE;
      d_cnt      <= '0;
      d_ack      <= 1'b0;
      d_err      <= 1'b0;
      d_rdata    <= '0;
      d_we_pend  <= 1'b0;
      d_err_pend <= 1'b0;
    end else begin
      d_state <= d_state_next;
      d_cnt   <= d_cnt_next;
      d_ack   <= d_ack_next;
      d_err   <= d_err_next;
      d_rdata <= d_rdata_next;
      if (d_accept) begin
        d_we_pend  <= d_we;
        d_err_pend <= !d_in_range;
      end
    end
  end

  // Data port next state: writes finish after one cycle, reads after RD_LATENCY.
  always_comb begin
    d_state_next = d_state;
    d_cnt_next   = d_cnt;
    d_ready      = 1'b0;
    d_ack_next   = 1'b0;
    d_err_next   = 1'b0;
    d_rdata_next = d_rdata;
    case (d_state)
      ST_IDLE: begin
        d_ready = 1'b1;
        if (d_req) begin
          d_state_next = ST_BUSY;
          d_cnt_next   = d_we ? '0 : CNT_LOAD;
        end
      end
      ST_BUSY: begin
        if (d_cnt == '0) begin
          d_state_next = ST_IDLE;
          d_ack_next   = 1'b1;
          d_err_next   = d_err_pend;
          if (!d_we_pend)
            d_rdata_next = d_buf;
        end else begin
          d_cnt_next = d_cnt - 1'b1;
        end
      end
      ST_CLEAR: begin
        if (clr_last)
          d_state_next = ST_IDLE;
      end
      default: d_state_next = ST_IDLE;
    endcase
  end

  // Fetch port state, latency counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_state <= RESET_STATE;
      i_cnt   <= '0;
      i_ack   <= 1'b0;
      i_rdata <= '0;
    end else begin
      i_state <= i_state_next;
      i_cnt   <= i_cnt_next;
      i_ack   <= i_ack_next;
      i_rdata <= i_rdata_next;
    end
  end

  // Fetch port next state: every request is a read of RD_LATENCY cycles.
  always_comb begin
    i_state_next = i_state;
    i_cnt_next   = i_cnt;
    i_ready      = 1'b0;
    i_ack_next   = 1'b0;
    i_rdata_next = i_rdata;
    case (i_state)
      ST_IDLE: begin
        i_ready = 1'b1;
        if (i_req) begin
          i_state_next = ST_BUSY;
          i_cnt_next   = CNT_LOAD;
        end
      end
      ST_BUSY: begin
        if (i_cnt == '0) begin
          i_state_next = ST_IDLE;
          i_ack_next   = 1'b1;
          i_rdata_next = i_buf;
        end else begin
          i_cnt_next = i_cnt - 1'b1;
        end
      end
      ST_CLEAR: begin
        if (clr_last)
          i_state_next = ST_IDLE;
      end
      default: i_state_next = ST_IDLE;
    endcase
  end

endmodule
